// File: rtl/fcs_append.sv
// RMII transmit framer: prefixes the payload dibit stream with preamble and SFD,
// appends the Ethernet CRC-32 FCS, then enforces the inter-frame gap.
// An upstream underrun aborts the frame with a deliberately corrupted FCS.
module fcs_append (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    input  logic       axiil,
    output logic       axiir,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       done,
    output logic       err
);

    localparam logic [31:0] CrcPoly  = 32'hEDB88320;
    localparam logic [31:0] CrcInit  = 32'hFFFFFFFF;
    localparam logic [1:0]  PreDibit = 2'b01;
    localparam logic [1:0]  SfdDibit = 2'b11;
    localparam logic [4:0]  PreLast  = 5'd31;
    localparam logic [4:0]  FcsEnd   = 5'd16;
    // The IDLE turnaround cycle is also low on the wire, so GAP lasts one cycle
    // less than the 48-dibit gap seen between back-to-back frames.
    localparam logic [5:0]  GapLast  = 6'd46;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StData,
        StFcs,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [5:0]  gap_q, gap_d;
    logic [31:0] crc_q, crc_d;
    logic        err_lat_q, err_lat_d;
    logic        ov_q, ov_d;
    logic [1:0]  od_q, od_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        take_payload;
    logic [31:0] crc_upd;
    logic [4:0]  fcs_idx;
    logic [31:0] fcs_word;
    logic [1:0]  fcs_dibit;

    // One reflected CRC-32 step for a single wire bit.
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        return (c >> 1) ^ ((c[0] ^ b) ? CrcPoly : 32'h0);
    endfunction

    assign axiir = (state_q == StData) || ((state_q == StPreamble) && (cnt_q == PreLast));

    assign crc_upd = crc_bit(crc_bit(crc_q, axiid[0]), axiid[1]);

    // After an underrun, dibit 0 already left on the abort edge, so the index runs one ahead.
    assign fcs_idx   = cnt_q + {4'd0, err_lat_q};
    assign fcs_word  = err_lat_q ? crc_q : ~crc_q;
    assign fcs_dibit = fcs_word[{fcs_idx[3:0], 1'b0} +: 2];

    assign axiov = ov_q;
    assign axiod = od_q;
    assign done  = done_q;
    assign err   = err_q;

    // Next-state and next-output decode; outputs are registered one cycle ahead of the wire.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        crc_d        = crc_q;
        err_lat_d    = err_lat_q;
        ov_d         = 1'b0;
        od_d         = 2'b00;
        done_d       = 1'b0;
        err_d        = 1'b0;
        take_payload = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (axiiv) begin
                    state_d   = StPreamble;
                    crc_d     = CrcInit;
                    err_lat_d = 1'b0;
                    ov_d      = 1'b1;
                    od_d      = PreDibit;
                end
            end
            StPreamble: begin
                ov_d = 1'b1;
                if (cnt_q != PreLast) begin
                    cnt_d = cnt_q + 5'd1;
                    od_d  = (cnt_q == PreLast - 5'd1) ? SfdDibit : PreDibit;
                end else begin
                    take_payload = 1'b1;
                end
            end
            StData: begin
                ov_d         = 1'b1;
                take_payload = 1'b1;
            end
            StFcs: begin
                if (fcs_idx == FcsEnd) begin
                    state_d   = StGap;
                    done_d    = 1'b1;
                    err_d     = err_lat_q;
                    err_lat_d = 1'b0;
                end else begin
                    ov_d  = 1'b1;
                    od_d  = fcs_dibit;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Ready is high here: either a dibit transfers or the source has underrun.
        if (take_payload) begin
            if (axiiv) begin
                od_d    = axiid;
                crc_d   = crc_upd;
                state_d = axiil ? StFcs : StData;
            end else begin
                // Abort: emit the running CRC uninverted so the far end sees a bad FCS.
                state_d   = StFcs;
                err_lat_d = 1'b1;
                od_d      = crc_q[1:0];
            end
        end

        if (state_d != state_q) begin
            cnt_d = 5'd0;
            gap_d = 6'd0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            gap_q     <= 6'd0;
            crc_q     <= CrcInit;
            err_lat_q <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= 2'b00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            crc_q     <= crc_d;
            err_lat_q <= err_lat_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_fcs_append.sv
// Directed bench for fcs_append: reset state, normal frames, 1-dibit frames,
// back-to-back gap, underrun abort and mid-frame reset.
module tb_fcs_append;

    logic       clk;
    logic       rst_n;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiil;
    logic       axiir;
    logic       axiov;
    logic [1:0] axiod;
    logic       done;
    logic       err;

    typedef struct packed {
        logic       iv;
        logic       ir;
        logic       dn;
        logic       er;
        logic       ov;
        logic [1:0] od;
    } smp_t;

    smp_t       trace[$];
    logic [1:0] pl[64];
    int         checks = 0;
    int         errors = 0;

    fcs_append dut (
        .clk  (clk),
        .rst_n(rst_n),
        .axiiv(axiiv),
        .axiid(axiid),
        .axiil(axiil),
        .axiir(axiir),
        .axiov(axiov),
        .axiod(axiod),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One sample per cycle, taken mid-cycle.
    always @(negedge clk) trace.push_back(smp_t'({axiiv, axiir, done, err, axiov, axiod}));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic fld(input smp_t s, input int which);
        case (which)
            0:       return s.iv;
            1:       return s.ir;
            2:       return s.dn;
            3:       return s.er;
            default: return s.ov;
        endcase
    endfunction

    function automatic int first_fld(input int which, input int from);
        for (int i = from; i < trace.size(); i++) if (fld(trace[i], which)) return i;
        return -1;
    endfunction

    function automatic int count_fld(input int which);
        int n = 0;
        for (int i = 0; i < trace.size(); i++) if (fld(trace[i], which)) n++;
        return n;
    endfunction

    function automatic int run_ov(input int from, input logic val);
        int n = 0;
        for (int i = from; i < trace.size(); i++) begin
            if (trace[i].ov !== val) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] word_at(input int from);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 16; k++) w[2*k +: 2] = trace[from + k].od;
        return w;
    endfunction

    function automatic int data_mism(input int from, input int n);
        int m = 0;
        for (int i = 0; i < n; i++)
            if (!trace[from + i].ov || trace[from + i].od !== pl[i]) m++;
        return m;
    endfunction

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [1:0] d);
        logic lsb;
        for (int i = 0; i < 2; i++) begin
            lsb = c[0] ^ d[i];
            c   = c >> 1;
            if (lsb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Present pl[0..n-1]; each dibit is held until a cycle with axiir high.
    task automatic send_frame(input int n, input bit mark_last, input bit keep_valid,
                              output bit ok);
        int idx = 0;
        int budget = 200;
        bit xfer;
        axiiv = 1'b1;
        axiid = pl[0];
        axiil = mark_last && (n == 1);
        while (idx < n && budget > 0) begin
            @(negedge clk);
            xfer = axiir;
            @(posedge clk);
            #1;
            budget--;
            if (xfer) begin
                idx++;
                if (idx < n) begin
                    axiid = pl[idx];
                    axiil = mark_last && (idx == n - 1);
                end
            end
        end
        if (!keep_valid) begin
            axiiv = 1'b0;
            axiil = 1'b0;
        end
        ok = (idx == n);
    endtask

    initial begin
        bit          ok, ok2;
        int          s, f, f2, m;
        logic [7:0]  byte_v;
        logic [31:0] exp_crc;

        rst_n = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;
        axiil = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_axiov", 32'(axiov), 32'h0);
        chk("rst_axiod", 32'(axiod), 32'h0);
        chk("rst_axiir", 32'(axiir), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // axiil without axiiv must not start anything
        trace.delete();
        axiil = 1'b1;
        repeat (6) @(negedge clk);
        axiil = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_axiil_ov", 32'(count_fld(4)), 32'd0);

        // Frame "123456789": 36 dibits
        for (int b = 0; b < 9; b++) begin
            byte_v = 8'h31 + 8'(b);
            for (int j = 0; j < 4; j++) pl[4*b + j] = byte_v[2*j +: 2];
        end
        trace.delete();
        send_frame(36, 1'b1, 1'b0, ok);
        chk("a_send", 32'(ok), 32'h1);
        repeat (110) @(posedge clk);
        #1;
        s = first_fld(0, 0);
        f = first_fld(4, 0);
        if (f < 0) f = 0;
        chk("a_latency", f, s + 1);
        chk("a_run", run_ov(f, 1'b1), 32'd84);
        chk("a_total_ov", count_fld(4), 32'd84);
        m = 0;
        for (int i = 0; i < 31; i++) if (trace[f + i].od !== 2'b01) m++;
        chk("a_preamble", m, 32'd0);
        chk("a_sfd", 32'(trace[f + 31].od), 32'h3);
        chk("a_payload", data_mism(f + 32, 36), 32'd0);
        chk("a_fcs", word_at(f + 68), 32'hCBF43926);
        chk("a_fcs_first4", {24'h0, trace[f+71].od, trace[f+70].od, trace[f+69].od,
                             trace[f+68].od}, 32'h26);
        chk("a_ready_cycles", count_fld(1), 32'd36);
        chk("a_done_count", count_fld(2), 32'd1);
        chk("a_done_pos", first_fld(2, 0), f + 84);
        chk("a_err_count", count_fld(3), 32'd0);

        // Back-to-back 1-dibit frames with axiiv held high
        pl[0] = 2'b00;
        trace.delete();
        send_frame(1, 1'b1, 1'b1, ok);
        send_frame(1, 1'b1, 1'b0, ok2);
        chk("b_send", {30'h0, ok, ok2}, 32'h3);
        repeat (80) @(posedge clk);
        #1;
        f = first_fld(4, 0);
        if (f < 0) f = 0;
        chk("b_run1", run_ov(f, 1'b1), 32'd49);
        chk("b_data1", 32'(trace[f + 32].od), 32'h0);
        chk("b_fcs1", word_at(f + 33), 32'h5B64C2B0);
        chk("b_ifg", run_ov(f + 49, 1'b0), 32'd48);
        f2 = first_fld(4, f + 49);
        if (f2 < 0) f2 = 0;
        chk("b_run2", run_ov(f2, 1'b1), 32'd49);
        chk("b_fcs2", word_at(f2 + 33), 32'h5B64C2B0);
        chk("b_done_pos", first_fld(2, 0), f + 49);
        chk("b_done_count", count_fld(2), 32'd2);
        chk("b_ready_cycles", count_fld(1), 32'd2);
        chk("b_err_count", count_fld(3), 32'd0);
        chk("b_tail_idle", 32'(run_ov(f2 + 49, 1'b0) >= 48), 32'h1);

        // Underrun after 10 payload dibits
        for (int j = 0; j < 4; j++) begin
            byte_v = 8'h31;
            pl[j] = byte_v[2*j +: 2];
            byte_v = 8'h32;
            pl[4 + j] = byte_v[2*j +: 2];
        end
        pl[8] = 2'b11;
        pl[9] = 2'b00;
        exp_crc = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) exp_crc = crc_model(exp_crc, pl[i]);
        trace.delete();
        send_frame(10, 1'b0, 1'b0, ok);
        chk("c_send", 32'(ok), 32'h1);
        repeat (110) @(posedge clk);
        #1;
        f = first_fld(4, 0);
        if (f < 0) f = 0;
        chk("c_run", run_ov(f, 1'b1), 32'd58);
        chk("c_payload", data_mism(f + 32, 10), 32'd0);
        chk("c_bad_fcs", word_at(f + 42), exp_crc);
        chk("c_done_pos", first_fld(2, 0), f + 58);
        chk("c_err_pos", first_fld(3, 0), f + 58);
        chk("c_done_count", count_fld(2), 32'd1);
        chk("c_err_count", count_fld(3), 32'd1);

        // Reset during FCS dibit 5 of a 1-dibit frame
        pl[0] = 2'b00;
        trace.delete();
        send_frame(1, 1'b1, 1'b0, ok);
        chk("d_send", 32'(ok), 32'h1);
        repeat (6) @(posedge clk);
        #5;
        chk("d_ov_before_rst", 32'(axiov), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("d_rst_ov", 32'(axiov), 32'h0);
        chk("d_rst_od", 32'(axiod), 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("d_no_done", count_fld(2), 32'd0);
        trace.delete();
        send_frame(1, 1'b1, 1'b0, ok);
        chk("d_send2", 32'(ok), 32'h1);
        repeat (80) @(posedge clk);
        #1;
        f = first_fld(4, 0);
        if (f < 0) f = 0;
        chk("d_run", run_ov(f, 1'b1), 32'd49);
        chk("d_fcs", word_at(f + 33), 32'h5B64C2B0);
        chk("d_done_pos", first_fld(2, 0), f + 49);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
